// File: rtl/fft_cap_pkg.sv
// Shared state encodings and width helpers for the FFT spectrum capture block.
// Widths follow LOG2N: the bin counter spans a full frame, RAM addresses span half of it.
package fft_cap_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_CAPTURE  = 2'd2;
    localparam logic [1:0] ST_READY    = 2'd3;

    function automatic int unsigned bin_w(input int unsigned log2n);
        return log2n;
    endfunction

    function automatic int unsigned addr_w(input int unsigned log2n);
        return log2n - 1;
    endfunction

endpackage

// File: rtl/fft_cap_ram.sv
// Simple dual-port RAM: one write port, one enabled and registered read port.
// No reset on the storage or the read register so it maps onto block RAM.
module fft_cap_ram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned AMP_W  = 43
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [AMP_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [AMP_W-1:0]  rd_data
);

    logic [AMP_W-1:0] mem [0:(1 << ADDR_W)-1];
    logic [AMP_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_spectrum_capture.sv
// Captures one half-spectrum frame of FFT bin magnitudes into RAM, tracks the
// peak bin, and holds the frame for readout until re-armed.
module fft_spectrum_capture
    import fft_cap_pkg::*;
#(
    parameter int unsigned LOG2N   = 10,
    parameter int unsigned AMP_W   = 43,
    parameter int unsigned SKIP_DC = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             fft_out_valid,
    input  logic [AMP_W-1:0] amp,
    input  logic             resync,
    input  logic             arm,
    output logic             busy,
    output logic             frame_done,
    output logic [LOG2N-2:0] peak_bin,
    output logic [AMP_W-1:0] peak_amp,
    input  logic             rd_en,
    input  logic [LOG2N-2:0] rd_addr,
    output logic [AMP_W-1:0] rd_data,
    output logic             rd_valid
);

    localparam int unsigned BIN_W  = bin_w(LOG2N);
    localparam int unsigned ADDR_W = addr_w(LOG2N);

    localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'((1 << ADDR_W) - 1);
    localparam logic [BIN_W-1:0]  SKIP_BIN  = BIN_W'(SKIP_DC);
    localparam logic [ADDR_W-1:0] SKIP_ADDR = ADDR_W'(SKIP_DC);

    logic [1:0]        state_q,      state_d;
    logic [BIN_W-1:0]  bin_cnt_q,    bin_cnt_d;
    logic [AMP_W-1:0]  run_max_q,    run_max_d;
    logic [ADDR_W-1:0] run_bin_q,    run_bin_d;
    logic [ADDR_W-1:0] peak_bin_q,   peak_bin_d;
    logic [AMP_W-1:0]  peak_amp_q,   peak_amp_d;
    logic              frame_done_q, frame_done_d;
    logic              rd_valid_q,   rd_valid_d;
    logic              rd_seen_q,    rd_seen_d;

    logic              beat;
    logic              ram_we;
    logic              rd_hit;
    logic [AMP_W-1:0]  ram_rd_data;
    logic [AMP_W-1:0]  base_max;
    logic [ADDR_W-1:0] base_bin;
    logic              take;
    logic [AMP_W-1:0]  upd_max;
    logic [ADDR_W-1:0] upd_bin;

    always_comb begin
        beat      = fft_out_valid && !resync;
        bin_cnt_d = bin_cnt_q;
        if (resync) begin
            bin_cnt_d = '0;
        end else if (fft_out_valid) begin
            bin_cnt_d = bin_cnt_q + 1'b1;
        end

        // The first beat of a frame compares against a zero max seeded at SKIP_DC,
        // which yields peak_bin=SKIP_DC for an all-zero frame and skips the DC bins.
        base_max = (state_q == ST_WAIT_SOF) ? '0 : run_max_q;
        base_bin = (state_q == ST_WAIT_SOF) ? SKIP_ADDR : run_bin_q;
        take     = (bin_cnt_q >= SKIP_BIN) && (amp > base_max);
        upd_max  = take ? amp : base_max;
        upd_bin  = take ? bin_cnt_q[ADDR_W-1:0] : base_bin;

        state_d      = state_q;
        run_max_d    = run_max_q;
        run_bin_d    = run_bin_q;
        peak_bin_d   = peak_bin_q;
        peak_amp_d   = peak_amp_q;
        frame_done_d = 1'b0;
        ram_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (beat && (bin_cnt_q == '0)) begin
                    ram_we    = 1'b1;
                    run_max_d = upd_max;
                    run_bin_d = upd_bin;
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (resync) begin
                    state_d = ST_WAIT_SOF;
                end else if (beat) begin
                    ram_we    = 1'b1;
                    run_max_d = upd_max;
                    run_bin_d = upd_bin;
                    if (bin_cnt_q == LAST_BIN) begin
                        state_d      = ST_READY;
                        frame_done_d = 1'b1;
                        peak_bin_d   = upd_bin;
                        peak_amp_d   = upd_max;
                    end
                end
            end
            ST_READY: begin
                if (arm) begin
                    state_d = ST_WAIT_SOF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_hit     = rd_en && (state_q == ST_READY);
        rd_valid_d = rd_hit;
        rd_seen_d  = rd_seen_q || rd_hit;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            bin_cnt_q    <= '0;
            run_max_q    <= '0;
            run_bin_q    <= '0;
            peak_bin_q   <= '0;
            peak_amp_q   <= '0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_seen_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_cnt_q    <= bin_cnt_d;
            run_max_q    <= run_max_d;
            run_bin_q    <= run_bin_d;
            peak_bin_q   <= peak_bin_d;
            peak_amp_q   <= peak_amp_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_seen_q    <= rd_seen_d;
        end
    end

    fft_cap_ram #(
        .ADDR_W (ADDR_W),
        .AMP_W  (AMP_W)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (ram_we),
        .wr_addr (bin_cnt_q[ADDR_W-1:0]),
        .wr_data (amp),
        .rd_en   (rd_hit),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset; mask it until the first honoured read.
    assign rd_data    = rd_seen_q ? ram_rd_data : '0;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q == ST_WAIT_SOF) || (state_q == ST_CAPTURE);
    assign frame_done = frame_done_q;
    assign peak_bin   = peak_bin_q;
    assign peak_amp   = peak_amp_q;

endmodule

// File: doc/fft_spectrum_capture.md
Name: fft_spectrum_capture

Overview:
- Consumer-side partner of the FFT wrapper: takes the per-bin magnitude stream (amp qualified by fft_out_valid) and captures one half-spectrum frame into an internal RAM.
- Tracks the peak bin of that frame and holds the frame for a host or readout engine.
- Sits directly downstream of the FFT wrapper's amp/fft_out_valid outputs. It is the reader end of the ADC-to-FFT sample path.

Parameters:
- LOG2N, 10, log2 of FFT length N; frame = N valid beats; stored bins = N/2.
- AMP_W, 43, magnitude width (matches FFT wrapper amp output).
- SKIP_DC, 1, number of lowest bins excluded from peak search (0 = include DC).

Ports:
- aclk  in  1  system clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- fft_out_valid  in  1  amp qualifier; one beat per FFT bin, gaps allowed.
- amp  in  AMP_W  bin magnitude, sampled when fft_out_valid=1.
- resync  in  1  single-cycle; forces bin counter to 0 (frame realignment).
- arm  in  1  single-cycle; request capture of the next whole frame.
- busy  out  1  1 in WAIT_SOF or CAPTURE.
- frame_done  out  1  one-cycle pulse when a frame becomes READY.
- peak_bin  out  LOG2N-1  index of maximum stored bin of last completed frame.
- peak_amp  out  AMP_W  magnitude at peak_bin.
- rd_en  in  1  read strobe, honoured only in READY.
- rd_addr  in  LOG2N-1  bin index to read.
- rd_data  out  AMP_W  stored magnitude, valid with rd_valid.
- rd_valid  out  1  asserted exactly 1 cycle after an honoured rd_en.

Behaviour:
- Reset (aresetn=0, async): state=IDLE, bin_cnt=0, busy=0, frame_done=0, peak_bin=0, peak_amp=0, rd_data=0, rd_valid=0. RAM contents undefined.
- Bin counter:
  - LOG2N bits; increments on every fft_out_valid beat in every state, wraps N-1 -> 0.
  - resync sets it to 0; resync wins over a coincident valid beat, and that beat is discarded.
- States: IDLE, WAIT_SOF, CAPTURE, READY.
  - IDLE: arm -> WAIT_SOF.
  - WAIT_SOF: on a valid beat with bin_cnt=0 -> write bin 0, initialise peak, -> CAPTURE.
  - CAPTURE: each valid beat writes amp to RAM[bin_cnt]. The beat at bin_cnt=N/2-1 is written, then -> READY with frame_done pulsed the next cycle. Bins N/2..N-1 are never stored.
  - READY: frame frozen, RAM writes blocked, rd port active. arm -> WAIT_SOF; the RAM keeps its contents until overwritten.
- arm during WAIT_SOF/CAPTURE is ignored. resync during CAPTURE aborts to WAIT_SOF, with no frame_done and peak outputs unchanged. resync in other states affects only the counter.
- Peak search:
  - Running max over bins SKIP_DC..N/2-1 of the current capture.
  - Strict greater-than compare, so ties keep the lower bin. If all eligible bins are 0, peak_bin=SKIP_DC.
  - peak_bin/peak_amp outputs update only at the READY transition, in the same cycle frame_done is asserted, and hold until the next completed frame.
- Readout:
  - rd_en in READY: rd_data=RAM[rd_addr] and rd_valid=1 on the next cycle.
  - Back-to-back reads give full throughput.
  - rd_en outside READY: rd_valid=0, rd_data holds its last value.
  - A read issued on the cycle arm leaves READY is still honoured.
- RAM: simple dual-port, N/2 x AMP_W, synchronous read; infers block RAM.

Decomposition:
- Package fft_cap_pkg: state enumeration (IDLE, WAIT_SOF, CAPTURE, READY) and derived widths (BIN_W=LOG2N, ADDR_W=LOG2N-1).
- One sub-module: fft_cap_ram, a simple dual-port synchronous RAM (1 write port, 1 registered read port), parameterised by ADDR_W and AMP_W.

Test Plan:
- Bench uses LOG2N=4 (N=16, 8 stored bins) and SKIP_DC=1.
- Reset/idle: hold aresetn=0 for 20 ns, then stream continuous valid -> all outputs 0, busy=0, no frame_done, rd_en gives rd_valid=0.
- Basic capture:
  - Stimulus: arm at bin_cnt=5, then amp=bin*100 continuous.
  - Required: capture starts at the next bin 0, and frame_done pulses once after bin 7 is written.
  - Reads of 0..7 return 0,100,...,700 with 1-cycle latency, and peak_bin=7, peak_amp=700.
- Peak rules:
  - amp=all 0x7FF except bin0=0xFFF and bins 3 and 5 =0x900 -> peak_bin=3, peak_amp=0x900 (DC skipped, tie keeps the lower bin).
  - All-zero frame -> peak_bin=1, peak_amp=0.
- Gapped valid: toggle fft_out_valid 1/0 every cycle -> same RAM and peak results as continuous streaming, and frame_done is delayed accordingly.
- resync abort: resync at stored bin 4 of a CAPTURE -> state WAIT_SOF and no frame_done; the next frame is captured from realigned bin 0; prior peak outputs are unchanged until the new frame_done.
- Hold and re-arm:
  - In READY, keep streaming 3 more frames with different data -> RAM and peak are unchanged, and back-to-back reads return the old frame.
  - arm -> busy=1, and a new frame is captured.
  - Assert aresetn=0 mid-CAPTURE -> immediate IDLE with all outputs 0.
